// File: rtl/asym_fifo_burst_arbiter.sv
// Round-robin arbiter with packet locking that feeds bursts from N_REQ producers
// into the push side of one asymmetric burst FIFO through a single output stage.
module asym_fifo_burst_arbiter #(
   parameter int  N_REQ      = 4,
   parameter int  N_IN       = 4,
   parameter int  DATA_WIDTH = 32,
   localparam int ID_W       = $clog2(N_REQ)
) (
   input  logic                                        clk_i,
   input  logic                                        rst_i,
   input  logic                                        flush_i,
   input  logic [N_REQ-1:0]                            req_valid_i,
   input  logic [N_REQ-1:0]                            req_last_i,
   input  logic [N_REQ-1:0][N_IN-1:0][DATA_WIDTH-1:0]  req_data_i,
   output logic [N_REQ-1:0]                            req_ready_o,
   output logic                                        fifo_push_o,
   output logic [N_IN-1:0][DATA_WIDTH-1:0]             fifo_data_o,
   input  logic                                        fifo_full_i,
   output logic                                        fifo_flush_o,
   output logic [ID_W-1:0]                             grant_id_o,
   output logic                                        locked_o,
   output logic [31:0]                                 stat_bursts_o
);

   // Handshake: a burst transfers on a cycle where req_valid_i[i] & req_ready_o[i];
   // ready is only offered to the arbitration winner when the output stage can load.
   typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

   state_e                           state_q, state_d;
   logic [ID_W-1:0]                  lock_id_q, lock_id_d;
   logic [ID_W-1:0]                  rr_q, rr_d;
   logic                             out_valid_q;
   logic [N_IN-1:0][DATA_WIDTH-1:0]  out_data_q;
   logic [ID_W-1:0]                  out_id_q;
   logic [31:0]                      stat_q;

   logic            push_fire, load_en, accept;
   logic            win_found, win_last;
   logic [ID_W-1:0] win_id;
   int unsigned     idx;

   assign push_fire = out_valid_q & ~fifo_full_i;
   assign load_en   = ~out_valid_q | push_fire;

   // Scan from the round-robin pointer; while locked only the owner is eligible.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_q) + k) % N_REQ;
         if (!win_found && req_valid_i[idx] &&
             (state_q == ST_IDLE || ID_W'(idx) == lock_id_q)) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

   assign accept   = win_found & load_en & ~flush_i & ~rst_i;
   assign win_last = req_last_i[win_id];

   always_comb begin
      req_ready_o = '0;
      if (accept) req_ready_o[win_id] = 1'b1;
   end

   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      rr_d      = rr_q;
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (!win_last) begin
                  state_d   = ST_LOCKED;
                  lock_id_d = win_id;
               end
            end
            ST_LOCKED: begin
               if (win_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
         // Pointer only moves at packet boundaries, so fairness is per packet.
         if (win_last) rr_d = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         lock_id_q   <= '0;
         rr_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
      end else if (flush_i) begin
         state_q     <= ST_IDLE;
         lock_id_q   <= '0;
         rr_q        <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         rr_q      <= rr_d;
         if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= req_data_i[win_id];
            out_id_q    <= win_id;
         end else if (push_fire) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   // Counter survives flush; only reset clears it.
   always_ff @(posedge clk_i) begin
      if (rst_i)          stat_q <= '0;
      else if (push_fire) stat_q <= stat_q + 32'd1;
   end

   assign fifo_push_o   = out_valid_q;
   assign fifo_data_o   = out_data_q;
   assign grant_id_o    = out_id_q;
   assign locked_o      = (state_q == ST_LOCKED);
   assign stat_bursts_o = stat_q;
   assign fifo_flush_o  = flush_i & ~rst_i;

endmodule

// File: tb/tb_asym_fifo_burst_arbiter.sv
// Directed scenarios followed by randomized traffic, checked cycle by cycle
// against a packet-level reference model and an expected-burst queue.
module tb_asym_fifo_burst_arbiter;

   localparam int N_REQ = 4;
   localparam int N_IN  = 4;
   localparam int DW    = 32;
   localparam int ID_W  = $clog2(N_REQ);
   localparam int EW    = ID_W + N_IN * DW;

   logic                               clk;
   logic                               rst;
   logic                               flush;
   logic [N_REQ-1:0]                   req_valid;
   logic [N_REQ-1:0]                   req_last;
   logic [N_REQ-1:0][N_IN-1:0][DW-1:0] req_data;
   logic [N_REQ-1:0]                   req_ready;
   logic                               fifo_push;
   logic [N_IN-1:0][DW-1:0]            fifo_data;
   logic                               full;
   logic                               fifo_flush;
   logic [ID_W-1:0]                    grant_id;
   logic                               locked;
   logic [31:0]                        stat_bursts;

   asym_fifo_burst_arbiter #(.N_REQ(N_REQ), .N_IN(N_IN), .DATA_WIDTH(DW)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .flush_i       (flush),
      .req_valid_i   (req_valid),
      .req_last_i    (req_last),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .fifo_push_o   (fifo_push),
      .fifo_data_o   (fifo_data),
      .fifo_full_i   (full),
      .fifo_flush_o  (fifo_flush),
      .grant_id_o    (grant_id),
      .locked_o      (locked),
      .stat_bursts_o (stat_bursts)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model: packet state plus the burst sitting in the output stage
   logic [EW-1:0] exp_q[$];
   logic          m_lock;
   int            m_owner;
   int            m_rr;
   logic [31:0]   m_cnt;
   logic          m_acc;
   int            m_win;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic new_burst(input int i, input logic last);
      req_valid[i] = 1'b1;
      req_last[i]  = last;
      for (int j = 0; j < N_IN; j++) req_data[i][j] = $urandom;
   endtask

   // One clock: check outputs against the model, advance the model, cross the edge.
   task automatic cycle();
      logic             push, load, found, acc;
      int               win, i;
      logic [N_REQ-1:0] exp_ready;
      #1;
      push  = (exp_q.size() != 0) && !full;
      load  = (exp_q.size() == 0) || push;
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         i = (m_rr + k) % N_REQ;
         if (!found && req_valid[i] && (!m_lock || i == m_owner)) begin
            found = 1'b1;
            win   = i;
         end
      end
      acc = found && load && !flush && !rst;
      exp_ready = '0;
      if (acc) exp_ready[win] = 1'b1;
      chk("ready", EW'(req_ready), EW'(exp_ready));
      chk("push", EW'(fifo_push), EW'(exp_q.size() != 0));
      chk("locked", EW'(locked), EW'(m_lock));
      chk("stat", EW'(stat_bursts), EW'(m_cnt));
      chk("fifo_flush", EW'(fifo_flush), EW'(flush && !rst));
      if (exp_q.size() != 0) chk("burst", {grant_id, fifo_data}, exp_q[0]);
      m_acc = acc;
      m_win = win;
      if (rst) begin
         exp_q.delete();
         m_lock = 1'b0; m_owner = 0; m_rr = 0; m_cnt = '0;
      end else begin
         if (push) begin
            m_cnt = m_cnt + 32'd1;
            void'(exp_q.pop_front());
         end
         if (flush) begin
            exp_q.delete();
            m_lock = 1'b0; m_rr = 0;
         end else if (acc) begin
            exp_q.push_back({ID_W'(win), req_data[win]});
            if (!req_last[win]) begin
               m_lock  = 1'b1;
               m_owner = win;
            end else begin
               m_lock = 1'b0;
               m_rr   = (win + 1) % N_REQ;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [N_IN-1:0][DW-1:0] held;
   logic [N_IN-1:0][DW-1:0] zero_data;
   int                      cnt1;

   initial begin
      rst = 1'b1; flush = 1'b0; full = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0; zero_data = '0;
      m_lock = 1'b0; m_owner = 0; m_rr = 0; m_cnt = '0; m_acc = 1'b0; m_win = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_push", EW'(fifo_push), '0);
      chk("rst_data", EW'(fifo_data), '0);
      chk("rst_grant", EW'(grant_id), '0);
      chk("rst_locked", EW'(locked), '0);
      chk("rst_stat", EW'(stat_bursts), '0);
      chk("rst_ready", EW'(req_ready), '0);
      chk("rst_fflush", EW'(fifo_flush), '0);

      // all four requesting single-burst packets: grants rotate 0,1,2,3,0
      for (int i = 0; i < N_REQ; i++) new_burst(i, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cycle();
         if (m_acc) new_burst(m_win, 1'b1);
         chk("t1_grant", EW'(grant_id), EW'(k % N_REQ));
         chk("t1_push", EW'(fifo_push), EW'(1));
      end
      chk("t1_stat4", EW'(stat_bursts), EW'(4));
      req_valid = '0;
      repeat (2) cycle();

      // locked three-burst packet from requester 1 while 2 waits
      new_burst(1, 1'b0);
      new_burst(2, 1'b1);
      cnt1 = 0;
      for (int j = 0; j < 4; j++) begin
         cycle();
         if (m_acc && m_win == 1) begin
            cnt1++;
            if (cnt1 == 1)      new_burst(1, 1'b0);
            else if (cnt1 == 2) new_burst(1, 1'b1);
            else                req_valid[1] = 1'b0;
         end
         if (m_acc && m_win == 2) req_valid[2] = 1'b0;
         chk("t2_grant", EW'(grant_id), (j < 3) ? EW'(1) : EW'(2));
         if (j < 2)  chk("t2_locked", EW'(locked), EW'(1));
         if (j == 2) chk("t2_unlocked", EW'(locked), '0);
      end
      cycle();

      // fifo full holds the stage; release pushes and accepts in the same cycle
      new_burst(0, 1'b1);
      held = req_data[0];
      cycle();
      req_valid[0] = 1'b0;
      full = 1'b1;
      new_burst(3, 1'b1);
      repeat (5) begin
         cycle();
         chk("t3_data", EW'(fifo_data), EW'(held));
         chk("t3_grant", EW'(grant_id), '0);
         chk("t3_ready", EW'(req_ready), '0);
      end
      full = 1'b0;
      #1;
      chk("t3_rel_ready", EW'(req_ready), EW'(4'b1000));
      cycle();
      req_valid[3] = 1'b0;
      chk("t3_rel_grant", EW'(grant_id), EW'(3));
      cycle();

      // single burst from 1 moves the pointer to 2, then flush a packet from 2
      new_burst(1, 1'b1);
      cycle();
      req_valid[1] = 1'b0;
      cycle();
      new_burst(2, 1'b0);
      cycle();
      new_burst(2, 1'b0);
      cycle();
      flush = 1'b1;
      new_burst(2, 1'b0);
      #1;
      chk("t4_fflush", EW'(fifo_flush), EW'(1));
      chk("t4_ready", EW'(req_ready), '0);
      cycle();
      flush = 1'b0;
      req_valid[2] = 1'b0;
      chk("t4_push", EW'(fifo_push), '0);
      chk("t4_locked", EW'(locked), '0);
      chk("t4_stat", EW'(stat_bursts), EW'(m_cnt));
      new_burst(1, 1'b1);
      new_burst(3, 1'b1);
      #1;
      chk("t4_rr_reset", EW'(req_ready), EW'(4'b0010));
      cycle();
      req_valid[1] = 1'b0;
      cycle();
      req_valid[3] = 1'b0;
      cycle();

      // reset while locked with a burst in the stage
      new_burst(0, 1'b0);
      cycle();
      rst = 1'b1;
      new_burst(0, 1'b0);
      cycle();
      rst = 1'b0;
      req_valid[0] = 1'b0;
      chk("t5_push", EW'(fifo_push), '0);
      chk("t5_grant", EW'(grant_id), '0);
      chk("t5_locked", EW'(locked), '0);
      chk("t5_stat", EW'(stat_bursts), '0);
      chk("t5_data", EW'(fifo_data), EW'(zero_data));
      new_burst(3, 1'b1);
      #1;
      chk("t5_ready3", EW'(req_ready), EW'(4'b1000));
      cycle();
      req_valid[3] = 1'b0;
      cycle();

      // counter wrap from all-ones
      force dut.stat_q = 32'hFFFF_FFFF;
      #1;
      release dut.stat_q;
      m_cnt = 32'hFFFF_FFFF;
      chk("t6_preload", EW'(stat_bursts), EW'(32'hFFFF_FFFF));
      new_burst(1, 1'b1);
      cycle();
      req_valid[1] = 1'b0;
      cycle();
      chk("t6_wrap", EW'(stat_bursts), '0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < N_REQ; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0) new_burst(i, $urandom_range(0, 2) != 0);
         full  = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 49) == 0);
         rst   = ($urandom_range(0, 149) == 0);
         cycle();
         if (m_acc) req_valid[m_win] = 1'b0;
      end
      rst = 1'b0; flush = 1'b0; full = 1'b0; req_valid = '0;
      repeat (3) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
